// File: rtl/frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : frame_sequencer_if
//  Purpose  : Command / status bundle between the button front end and the
//             frame sequencer. The optional LOOP_LIMIT_EN build adds the
//             loop-limit input and the playback-complete pulse.
//  Revision : 1.0  initial release
// ============================================================================
interface frame_sequencer_if;
   logic       start;
   logic       stop;
   logic       step;
   logic [2:0] speed;
   logic       dir;
   logic [4:0] fm_no;
   logic       frame_stb;
   logic [1:0] state;
`ifdef LOOP_LIMIT_EN
   logic [3:0] loops;
   logic       done;

   modport master (
      output start, stop, step, speed, dir, loops,
      input  fm_no, frame_stb, state, done
   );

   modport slave (
      input  start, stop, step, speed, dir, loops,
      output fm_no, frame_stb, state, done
   );
`else
   modport master (
      output start, stop, step, speed, dir,
      input  fm_no, frame_stb, state
   );

   modport slave (
      input  start, stop, step, speed, dir,
      output fm_no, frame_stb, state
   );
`endif
endinterface
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_sequencer
//  Purpose  : Produces the 5-bit frame number for the LED pattern decoder.
//             A prescaler divides clk down to the selected frame rate and the
//             frame counter steps up or down modulo 32. Run / pause / stop /
//             single-step commands come from debounced button pulses.
//  Options  : LOOP_LIMIT_EN - stop playback after a programmable number of
//             full wraps and pulse done.
//  Revision : 1.0  initial release
// ============================================================================
module frame_sequencer #(
   parameter int CNT_W    = 24,
   parameter int BASE_DIV = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   frame_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_base_div = CNT_W'(BASE_DIV);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [4:0]       r_fm_no;
   logic [4:0]       w_fm_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_frame_stb;
   logic             w_stb_nxt;

   logic [CNT_W-1:0] w_shifted;
   logic [CNT_W-1:0] w_period_m1;
   logic             w_tick;
   logic             w_cmd_stop;
   logic             w_cmd_start;
   logic             w_cmd_step;
   logic [4:0]       w_fm_adv;
   logic             w_wrap;

`ifdef LOOP_LIMIT_EN
   logic [3:0]       r_loop_cnt;
   logic [3:0]       w_loop_nxt;
   logic [3:0]       w_loop_inc;
   logic             w_loop_hit;
   logic             r_done;
   logic             w_done_nxt;
`endif

   // Frame period minus one; a shift to zero is clamped to a one-cycle period.
   always_comb begin
      w_shifted   = c_base_div >> bus.speed;
      w_period_m1 = (w_shifted == '0) ? '0 : (w_shifted - CNT_W'(1));
      w_tick      = (r_cnt >= w_period_m1);
   end

   // Command priority stop > start > step, plus next-frame and wrap detection.
   always_comb begin
      w_cmd_stop  = bus.stop;
      w_cmd_start = bus.start & ~bus.stop;
      w_cmd_step  = bus.step & ~bus.stop & ~bus.start;
      w_fm_adv    = bus.dir ? (r_fm_no - 5'd1) : (r_fm_no + 5'd1);
      w_wrap      = bus.dir ? (r_fm_no == 5'd0) : (r_fm_no == 5'd31);
   end

`ifdef LOOP_LIMIT_EN
   // Saturating wrap count so loops=0 (play forever) can never roll over.
   always_comb begin
      w_loop_inc = (r_loop_cnt == 4'hF) ? 4'hF : (r_loop_cnt + 4'd1);
      w_loop_hit = (bus.loops != 4'd0) && (w_loop_inc >= bus.loops);
   end
`endif

   // Next-state and next-output decode for the playback controller.
   always_comb begin
      w_state_nxt = r_state;
      w_fm_nxt    = r_fm_no;
      w_cnt_nxt   = r_cnt;
      w_stb_nxt   = 1'b0;
`ifdef LOOP_LIMIT_EN
      w_loop_nxt  = r_loop_cnt;
      w_done_nxt  = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_cmd_start) begin
               w_state_nxt = ST_RUN;
               w_fm_nxt    = 5'd0;
               w_cnt_nxt   = '0;
`ifdef LOOP_LIMIT_EN
               w_loop_nxt  = 4'd0;
`endif
            end else if (w_cmd_step) begin
               w_fm_nxt  = w_fm_adv;
               w_stb_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            // start and step are ignored while running; only stop interrupts.
            if (w_cmd_stop) begin
               w_state_nxt = ST_PAUSE;
            end else if (w_tick) begin
               w_cnt_nxt = '0;
               w_fm_nxt  = w_fm_adv;
               w_stb_nxt = 1'b1;
`ifdef LOOP_LIMIT_EN
               if (w_wrap) begin
                  w_loop_nxt = w_loop_inc;
                  if (w_loop_hit) begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
               end
`endif
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_PAUSE: begin
            // Prescaler count is frozen here so resume finishes the partial frame.
            if (w_cmd_stop) begin
               w_state_nxt = ST_IDLE;
               w_fm_nxt    = 5'd0;
            end else if (w_cmd_start) begin
               w_state_nxt = ST_RUN;
            end else if (w_cmd_step) begin
               w_fm_nxt  = w_fm_adv;
               w_stb_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_fm_nxt    = 5'd0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_fm_no     <= 5'd0;
         r_cnt       <= '0;
         r_frame_stb <= 1'b0;
`ifdef LOOP_LIMIT_EN
         r_loop_cnt  <= 4'd0;
         r_done      <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_fm_no     <= w_fm_nxt;
         r_cnt       <= w_cnt_nxt;
         r_frame_stb <= w_stb_nxt;
`ifdef LOOP_LIMIT_EN
         r_loop_cnt  <= w_loop_nxt;
         r_done      <= w_done_nxt;
`endif
      end
   end

   assign bus.fm_no     = r_fm_no;
   assign bus.frame_stb = r_frame_stb;
   assign bus.state     = r_state;
`ifdef LOOP_LIMIT_EN
   assign bus.done      = r_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_sequencer
//  Purpose  : Self-checking bench for frame_sequencer (BASE_DIV=4, CNT_W=4).
//             A frame-level reference model is compared against the DUT on
//             every clock edge and on reset; directed sequences add literal
//             expectations. Define LOOP_LIMIT_EN to cover the loop limit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_sequencer;

   localparam int c_base_div = 4;
   localparam int c_cnt_w    = 4;
   localparam int c_idle     = 0;
   localparam int c_run      = 1;
   localparam int c_pause    = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   frame_sequencer_if bus ();

   frame_sequencer #(
      .CNT_W    (c_cnt_w),
      .BASE_DIV (c_base_div)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: playback state, frame number, cycles since last frame.
   int m_state = c_idle;
   int m_fm    = 0;
   int m_cnt   = 0;
   int m_stb   = 0;
   int m_done  = 0;
   int m_wraps = 0;

   function automatic int next_frame(input int fm, input int down);
      return down ? ((fm + 31) % 32) : ((fm + 1) % 32);
   endfunction

   always @(posedge clk or posedge rst) begin
      int p;
      int nf;
      bit wrapped;
      if (rst) begin
         m_state = c_idle; m_fm = 0; m_cnt = 0; m_stb = 0; m_done = 0; m_wraps = 0;
      end else begin
         p = c_base_div >> bus.speed;
         if (p < 1) p = 1;
         nf      = next_frame(m_fm, int'(bus.dir));
         wrapped = bus.dir ? (m_fm == 0) : (m_fm == 31);
         m_stb   = 0;
         m_done  = 0;
         if (m_state == c_idle) begin
            if (bus.stop) begin
               // ignored
            end else if (bus.start) begin
               m_state = c_run; m_fm = 0; m_cnt = 0; m_wraps = 0;
            end else if (bus.step) begin
               m_fm = nf; m_stb = 1;
            end
         end else if (m_state == c_run) begin
            if (bus.stop) begin
               m_state = c_pause;
            end else if (m_cnt + 1 >= p) begin
               m_fm = nf; m_cnt = 0; m_stb = 1;
`ifdef LOOP_LIMIT_EN
               if (wrapped) begin
                  m_wraps = m_wraps + 1;
                  if (bus.loops != 0 && m_wraps >= int'(bus.loops)) begin
                     m_done = 1; m_state = c_idle;
                  end
               end
`endif
            end else begin
               m_cnt = m_cnt + 1;
            end
         end else begin
            if (bus.stop) begin
               m_state = c_idle; m_fm = 0;
            end else if (bus.start) begin
               m_state = c_run;
            end else if (bus.step) begin
               m_fm = nf; m_stb = 1;
            end
         end
      end
      #1;
      chk("model_fm_no", bus.fm_no, m_fm);
      chk("model_frame_stb", bus.frame_stb, m_stb);
      chk("model_state", bus.state, m_state);
`ifdef LOOP_LIMIT_EN
      chk("model_done", bus.done, m_done);
`endif
   end

   task automatic pulse(input logic s, input logic t, input logic p);
      @(negedge clk);
      bus.start = s; bus.stop = t; bus.step = p;
      @(negedge clk);
      bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0;
   endtask

   initial begin
      int n;
      bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0;
      bus.speed = 3'd0; bus.dir = 1'b0;
`ifdef LOOP_LIMIT_EN
      bus.loops = 4'd0;
`endif
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_fm_no", bus.fm_no, 0);
      chk("reset_state", bus.state, 0);
      chk("reset_stb", bus.frame_stb, 0);

      // Start from IDLE at speed 0: strobes at edges 4, 8, 12.
      pulse(1'b1, 1'b0, 1'b0);
      chk("start_state", bus.state, 1);
      chk("start_fm_no", bus.fm_no, 0);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         chk("p4_stb", bus.frame_stb, (k % 4 == 0) ? 1 : 0);
         if (k % 4 == 0) chk("p4_fm_no", bus.fm_no, k / 4);
      end

      // Asynchronous reset while running at frame 7.
      repeat (16) @(posedge clk);
      #1;
      chk("pre_rst_fm_no", bus.fm_no, 7);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_fm_no", bus.fm_no, 0);
      chk("async_rst_state", bus.state, 0);
      chk("async_rst_stb", bus.frame_stb, 0);
      @(negedge clk);
      rst = 1'b0;

      // speed 2 gives P=1: one frame per edge, then count down through wrap.
      bus.speed = 3'd2;
      pulse(1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("p1_first_fm_no", bus.fm_no, 1);
      @(negedge clk);
      bus.dir = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("down_fm_no", bus.fm_no, (k == 0) ? 0 : 32 - k);
         chk("down_stb", bus.frame_stb, 1);
      end

      // Back to P=4 counting up; pause one cycle into the frame at 5.
      @(negedge clk);
      bus.speed = 3'd0; bus.dir = 1'b0;
      n = 0;
      while (bus.fm_no != 5'd5 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wait_fm5_in_time", (n < 100) ? 1 : 0, 1);
      @(posedge clk);
      pulse(1'b0, 1'b1, 1'b0);
      chk("pause_state", bus.state, 2);
      chk("pause_fm_no", bus.fm_no, 5);
      chk("pause_stb", bus.frame_stb, 0);
      pulse(1'b0, 1'b0, 1'b1);
      chk("step1_fm_no", bus.fm_no, 6);
      chk("step1_stb", bus.frame_stb, 1);
      chk("step1_state", bus.state, 2);
      pulse(1'b0, 1'b0, 1'b1);
      chk("step2_fm_no", bus.fm_no, 7);
      chk("step2_stb", bus.frame_stb, 1);

      // Resume: one of four prescale cycles already spent, so strobe on edge 3.
      pulse(1'b1, 1'b0, 1'b0);
      chk("resume_state", bus.state, 1);
      chk("resume_stb", bus.frame_stb, 0);
      @(posedge clk); #1;
      chk("resume_e1_stb", bus.frame_stb, 0);
      @(posedge clk); #1;
      chk("resume_e2_stb", bus.frame_stb, 0);
      @(posedge clk); #1;
      chk("resume_e3_stb", bus.frame_stb, 1);
      chk("resume_e3_fm_no", bus.fm_no, 8);

      // All three commands at once in RUN: stop wins.
      pulse(1'b1, 1'b1, 1'b1);
      chk("prio_state", bus.state, 2);
      chk("prio_fm_no", bus.fm_no, 8);
      chk("prio_stb", bus.frame_stb, 0);

      // Stop from PAUSE halts; stop in IDLE does nothing; step down wraps 0->31.
      pulse(1'b0, 1'b1, 1'b0);
      chk("halt_state", bus.state, 0);
      chk("halt_fm_no", bus.fm_no, 0);
      pulse(1'b0, 1'b1, 1'b0);
      chk("idle_stop_state", bus.state, 0);
      bus.dir = 1'b1;
      pulse(1'b0, 1'b0, 1'b1);
      chk("idle_step_fm_no", bus.fm_no, 31);
      chk("idle_step_stb", bus.frame_stb, 1);
      chk("idle_step_state", bus.state, 0);

      // start beats step; start from IDLE clears the frame without a strobe.
      bus.dir = 1'b0;
      pulse(1'b1, 1'b0, 1'b1);
      chk("start_step_state", bus.state, 1);
      chk("start_step_fm_no", bus.fm_no, 0);
      chk("start_step_stb", bus.frame_stb, 0);

      // Shorten the period mid-frame: count 2 already exceeds new P-1=1.
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_speed_stb", bus.frame_stb, 0);
      @(negedge clk);
      bus.speed = 3'd1;
      @(posedge clk); #1;
      chk("speed_chg_stb", bus.frame_stb, 1);
      chk("speed_chg_fm_no", bus.fm_no, 1);
      @(negedge clk);
      bus.speed = 3'd7;
      @(posedge clk); #1;
      chk("clamp_fm_no", bus.fm_no, 2);
      @(posedge clk); #1;
      chk("clamp2_fm_no", bus.fm_no, 3);
      chk("clamp2_stb", bus.frame_stb, 1);

      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      chk("final_halt_state", bus.state, 0);

`ifdef LOOP_LIMIT_EN
      // One full wrap at P=1 then automatic return to IDLE.
      bus.loops = 4'd1; bus.speed = 3'd2; bus.dir = 1'b0;
      pulse(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 31; k++) begin
         @(posedge clk); #1;
         chk("loop_fm_no", bus.fm_no, k);
         chk("loop_done_low", bus.done, 0);
      end
      @(posedge clk); #1;
      chk("loop_end_fm_no", bus.fm_no, 0);
      chk("loop_end_done", bus.done, 1);
      chk("loop_end_state", bus.state, 0);
      chk("loop_end_stb", bus.frame_stb, 1);
      @(posedge clk); #1;
      chk("loop_after_done", bus.done, 0);
      chk("loop_after_stb", bus.frame_stb, 0);
`endif

      repeat (2) @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
